// File: rtl/spill_gen_pkg.sv
// Shared definitions for the spill/live timing generator.
package spill_gen_pkg;

  localparam int unsigned SG_LEN_W = 32;
  localparam int unsigned SG_CNT_W = 12;

  typedef enum logic [1:0] {
    SG_IDLE = 2'd0,
    SG_ON   = 2'd1,
    SG_OFF  = 2'd2
  } sg_state_e;

endpackage

// File: rtl/spill_gen_timer.sv
// Loadable down-counter with a terminal-count flag; shared by the ON and OFF phases.
module spill_gen_timer
  import spill_gen_pkg::*;
#(
  parameter int unsigned LEN_W = SG_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  output logic             tc_c
);

  logic [LEN_W-1:0] count_q;
  logic [LEN_W-1:0] count_d;

  // Stops at zero so a stale phase never wraps.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_c = (count_q == '0);

endmodule

// File: rtl/spill_gen.sv
// Spill/live timing generator: start pulse, live gate for on_len cycles, gap of off_len cycles.
module spill_gen
  import spill_gen_pkg::*;
#(
  parameter int unsigned LEN_W = SG_LEN_W,
  parameter int unsigned CNT_W = SG_CNT_W
) (
  input  logic             clk,
  input  logic             system_rst_n,
  input  logic             enable,
  input  logic             live_enabled,
  input  logic [LEN_W-1:0] on_len,
  input  logic [LEN_W-1:0] off_len,
  input  logic             gen_clr,
  output logic             out_start,
  output logic             out_end,
  output logic             live,
  output logic             busy,
  output logic [CNT_W-1:0] gen_cnt
);

  sg_state_e        state_q, state_d;
  logic [LEN_W-1:0] off_len_q, off_len_d;
  logic             start_q, start_d;
  logic             end_q, end_d;
  logic             live_q, live_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] gen_cnt_q, gen_cnt_d;

  logic             tmr_load;
  logic [LEN_W-1:0] tmr_val;
  logic             tmr_tc_c;
  logic             go_c;
  logic [LEN_W-1:0] on_load_c;
  logic [LEN_W-1:0] off_load_c;

  assign go_c       = enable && live_enabled;
  // A zero length behaves like one cycle.
  assign on_load_c  = (on_len == '0) ? '0 : on_len - LEN_W'(1);
  assign off_load_c = (off_len_q == '0) ? '0 : off_len_q - LEN_W'(1);

  spill_gen_timer #(.LEN_W(LEN_W)) u_timer (
    .clk      (clk),
    .rst_n    (system_rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc_c     (tmr_tc_c)
  );

  always_comb begin
    state_d   = state_q;
    off_len_d = off_len_q;
    tmr_load  = 1'b0;
    tmr_val   = on_load_c;
    start_d   = 1'b0;
    end_d     = 1'b0;
    gen_cnt_d = gen_cnt_q;

    case (state_q)
      SG_IDLE: begin
        if (go_c) begin
          state_d   = SG_ON;
          tmr_load  = 1'b1;
          off_len_d = off_len;
          start_d   = 1'b1;
        end
      end
      SG_ON: begin
        if (tmr_tc_c) begin
          state_d  = SG_OFF;
          tmr_load = 1'b1;
          tmr_val  = off_load_c;
          end_d    = 1'b1;
        end
      end
      SG_OFF: begin
        if (tmr_tc_c) begin
          if (go_c) begin
            state_d   = SG_ON;
            tmr_load  = 1'b1;
            off_len_d = off_len;
            start_d   = 1'b1;
          end else begin
            state_d = SG_IDLE;
          end
        end
      end
      default: state_d = SG_IDLE;
    endcase

    // Saturating spill count; a clear coinciding with a start counts that start.
    if (gen_clr) begin
      gen_cnt_d = start_d ? CNT_W'(1) : '0;
    end else if (start_d && (gen_cnt_q != {CNT_W{1'b1}})) begin
      gen_cnt_d = gen_cnt_q + CNT_W'(1);
    end

    live_d = (state_d == SG_ON);
    busy_d = (state_d != SG_IDLE);
  end

  always_ff @(posedge clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      state_q   <= SG_IDLE;
      off_len_q <= '0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
      live_q    <= 1'b0;
      busy_q    <= 1'b0;
      gen_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      off_len_q <= off_len_d;
      start_q   <= start_d;
      end_q     <= end_d;
      live_q    <= live_d;
      busy_q    <= busy_d;
      gen_cnt_q <= gen_cnt_d;
    end
  end

  assign out_start = start_q;
  assign out_end   = end_q;
  assign live      = live_q;
  assign busy      = busy_q;
  assign gen_cnt   = gen_cnt_q;

endmodule

// File: tb/tb_spill_gen.sv
// Directed self-checking bench for spill_gen, including a 2-bit counter instance for saturation.
module tb_spill_gen;

  logic        clk;
  logic        system_rst_n;
  logic        enable;
  logic        live_enabled;
  logic [31:0] on_len;
  logic [31:0] off_len;
  logic        gen_clr;

  logic        out_start, out_end, live, busy;
  logic [11:0] gen_cnt;
  logic        out_start2, out_end2, live2, busy2;
  logic [1:0]  gen_cnt2;

  int checks;
  int failures;

  spill_gen #(.LEN_W(32), .CNT_W(12)) dut (
    .clk          (clk),
    .system_rst_n (system_rst_n),
    .enable       (enable),
    .live_enabled (live_enabled),
    .on_len       (on_len),
    .off_len      (off_len),
    .gen_clr      (gen_clr),
    .out_start    (out_start),
    .out_end      (out_end),
    .live         (live),
    .busy         (busy),
    .gen_cnt      (gen_cnt)
  );

  spill_gen #(.LEN_W(32), .CNT_W(2)) dut2 (
    .clk          (clk),
    .system_rst_n (system_rst_n),
    .enable       (enable),
    .live_enabled (live_enabled),
    .on_len       (on_len),
    .off_len      (off_len),
    .gen_clr      (gen_clr),
    .out_start    (out_start2),
    .out_end      (out_end2),
    .live         (live2),
    .busy         (busy2),
    .gen_cnt      (gen_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    system_rst_n = 1'b0;
    enable       = 1'b0;
    live_enabled = 1'b0;
    on_len       = 32'd1;
    off_len      = 32'd1;
    gen_clr      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    system_rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s wait_idle: busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({out_start, out_end, live, busy} !== 4'b0000 || gen_cnt !== 12'd0) begin
      failures++;
      $display("FAIL reset: start/end/live/busy=%b%b%b%b gen_cnt=%0d, required 0000 and 0",
               out_start, out_end, live, busy, gen_cnt);
    end
    checks++;
    if ({out_start2, out_end2, live2, busy2} !== 4'b0000 || gen_cnt2 !== 2'd0) begin
      failures++;
      $display("FAIL reset2: start/end/live/busy=%b%b%b%b gen_cnt=%0d, required 0000 and 0",
               out_start2, out_end2, live2, busy2, gen_cnt2);
    end
  endtask

  task automatic test_basic();
    do_reset();
    on_len = 32'd3; off_len = 32'd2; enable = 1'b1; live_enabled = 1'b1;
    for (int k = 0; k < 15; k++) begin
      logic el, es, ee;
      step();
      el = (k % 5) < 3;
      es = (k % 5) == 0;
      ee = (k % 5) == 3;
      checks++;
      if (live !== el || out_start !== es || out_end !== ee || busy !== 1'b1) begin
        failures++;
        $display("FAIL basic k=%0d: live/start/end/busy=%b%b%b%b, required %b%b%b1",
                 k, live, out_start, out_end, busy, el, es, ee);
      end
      checks++;
      if (gen_cnt !== 12'(k / 5 + 1)) begin
        failures++;
        $display("FAIL basic_cnt k=%0d: gen_cnt=%0d, required %0d", k, gen_cnt, k / 5 + 1);
      end
    end
    enable = 1'b0;
    wait_idle("basic");
  endtask

  task automatic test_live_enabled();
    do_reset();
    on_len = 32'd2; off_len = 32'd2; enable = 1'b1; live_enabled = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (out_start !== 1'b0 || busy !== 1'b0 || live !== 1'b0) begin
        failures++;
        $display("FAIL blocked k=%0d: start/busy/live=%b%b%b, required 000", k, out_start, busy, live);
      end
    end
    live_enabled = 1'b1;
    step();
    checks++;
    if (out_start !== 1'b1 || live !== 1'b1 || busy !== 1'b1 || gen_cnt !== 12'd1) begin
      failures++;
      $display("FAIL unblocked: start/live/busy=%b%b%b gen_cnt=%0d, required 111 and 1",
               out_start, live, busy, gen_cnt);
    end
    enable = 1'b0;
    wait_idle("live_enabled");
  endtask

  task automatic test_enable_drop();
    do_reset();
    on_len = 32'd4; off_len = 32'd3; enable = 1'b1; live_enabled = 1'b1;
    for (int k = 0; k < 9; k++) begin
      logic el, es, ee, eb;
      step();
      if (k == 1) enable = 1'b0;
      el = k < 4;
      es = k == 0;
      ee = k == 4;
      eb = k < 7;
      checks++;
      if (live !== el || out_start !== es || out_end !== ee || busy !== eb) begin
        failures++;
        $display("FAIL enable_drop k=%0d: live/start/end/busy=%b%b%b%b, required %b%b%b%b",
                 k, live, out_start, out_end, busy, el, es, ee, eb);
      end
    end
    checks++;
    if (gen_cnt !== 12'd1) begin
      failures++;
      $display("FAIL enable_drop_cnt: gen_cnt=%0d, required 1", gen_cnt);
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    on_len = 32'd0; off_len = 32'd0; enable = 1'b1; live_enabled = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic el, ee;
      step();
      el = (k % 2) == 0;
      ee = (k % 2) == 1;
      checks++;
      if (live !== el || out_start !== el || out_end !== ee) begin
        failures++;
        $display("FAIL zero_len k=%0d: live/start/end=%b%b%b, required %b%b%b",
                 k, live, out_start, out_end, el, el, ee);
      end
    end
    checks++;
    if (gen_cnt !== 12'd4) begin
      failures++;
      $display("FAIL zero_len_cnt: gen_cnt=%0d, required 4", gen_cnt);
    end
    enable = 1'b0;
    wait_idle("zero_len");
  endtask

  task automatic test_async_reset();
    do_reset();
    on_len = 32'd5; off_len = 32'd2; enable = 1'b1; live_enabled = 1'b1;
    step();
    step();
    checks++;
    if (live !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: live/busy=%b%b, required 11", live, busy);
    end
    #2;
    system_rst_n = 1'b0;
    enable = 1'b0;
    #1;
    checks++;
    if (live !== 1'b0 || busy !== 1'b0 || gen_cnt !== 12'd0 || out_start !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: live/busy/start=%b%b%b gen_cnt=%0d, required 000 and 0",
               live, busy, out_start, gen_cnt);
    end
    #2;
    system_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (busy !== 1'b0 || live !== 1'b0 || out_start !== 1'b0) begin
        failures++;
        $display("FAIL post_reset k=%0d: busy/live/start=%b%b%b, required 000", k, busy, live, out_start);
      end
    end
    enable = 1'b1;
    step();
    checks++;
    if (out_start !== 1'b1 || gen_cnt !== 12'd1) begin
      failures++;
      $display("FAIL restart: start=%b gen_cnt=%0d, required 1 and 1", out_start, gen_cnt);
    end
    enable = 1'b0;
    wait_idle("async_reset");
  endtask

  task automatic test_saturate_clear();
    do_reset();
    on_len = 32'd1; off_len = 32'd1; enable = 1'b1; live_enabled = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      if (k % 2 == 0) begin
        logic [1:0] ec;
        ec = (k / 2 + 1 > 3) ? 2'd3 : 2'(k / 2 + 1);
        checks++;
        if (out_start2 !== 1'b1 || gen_cnt2 !== ec) begin
          failures++;
          $display("FAIL saturate k=%0d: start=%b gen_cnt=%0d, required 1 and %0d",
                   k, out_start2, gen_cnt2, ec);
        end
      end
      if (k == 8) enable = 1'b0;
    end
    step();
    step();
    checks++;
    if (busy2 !== 1'b0 || gen_cnt2 !== 2'd3) begin
      failures++;
      $display("FAIL sat_idle: busy=%b gen_cnt=%0d, required 0 and 3", busy2, gen_cnt2);
    end
    gen_clr = 1'b1;
    step();
    gen_clr = 1'b0;
    checks++;
    if (gen_cnt2 !== 2'd0) begin
      failures++;
      $display("FAIL clear: gen_cnt=%0d, required 0", gen_cnt2);
    end
    enable = 1'b1;
    step();
    enable = 1'b0;
    checks++;
    if (out_start2 !== 1'b1 || gen_cnt2 !== 2'd1) begin
      failures++;
      $display("FAIL after_clear: start=%b gen_cnt=%0d, required 1 and 1", out_start2, gen_cnt2);
    end
    step();
    step();
    checks++;
    if (busy2 !== 1'b0) begin
      failures++;
      $display("FAIL clr_idle: busy=%b, required 0", busy2);
    end
    gen_clr = 1'b1;
    enable  = 1'b1;
    step();
    gen_clr = 1'b0;
    enable  = 1'b0;
    checks++;
    if (out_start2 !== 1'b1 || gen_cnt2 !== 2'd1) begin
      failures++;
      $display("FAIL clear_with_start: start=%b gen_cnt=%0d, required 1 and 1", out_start2, gen_cnt2);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    system_rst_n = 1'b0;
    enable       = 1'b0;
    live_enabled = 1'b0;
    on_len       = 32'd1;
    off_len      = 32'd1;
    gen_clr      = 1'b0;
    test_reset();
    test_basic();
    test_live_enabled();
    test_enable_drop();
    test_zero_len();
    test_async_reset();
    test_saturate_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
